// File: rtl/rgbw_frame_decoder.sv
// Decodes SPI byte frames (0xA5 header, R, G, B, W) into four committed 8-bit duty values.
// Optional macro RGBW_FRAME_CHECKSUM_EN appends a checksum byte (R^G^B^W) to each frame.
module rgbw_frame_decoder (
   input  logic       clk,
   input  logic       reset,
   input  logic       cs,
   input  logic       byte_rdy,
   input  logic [7:0] byte_in,
   output logic [7:0] red,
   output logic [7:0] green,
   output logic [7:0] blue,
   output logic [7:0] white,
   output logic       update,
   output logic       frame_err,
   output logic       busy
);

`ifdef RGBW_FRAME_CHECKSUM_EN
   typedef enum logic [2:0] {IDLE, GET_R, GET_G, GET_B, GET_W, GET_CHK, COMMIT} state_t;
`else
   typedef enum logic [2:0] {IDLE, GET_R, GET_G, GET_B, GET_W, COMMIT} state_t;
`endif

   state_t     state_q, state_d;
   logic       rdy_q;
   logic [7:0] sh_r_q, sh_r_d, sh_g_q, sh_g_d, sh_b_q, sh_b_d, sh_w_q, sh_w_d;
   logic [7:0] red_q, red_d, green_q, green_d, blue_q, blue_d, white_q, white_d;
   logic       frame_err_q, frame_err_d;
   logic       accept;

   // Rising edge of the strobe only, so a two-cycle strobe is consumed once.
   assign accept = byte_rdy & ~rdy_q & ~cs;

   always_comb begin
      state_d     = state_q;
      sh_r_d      = sh_r_q;
      sh_g_d      = sh_g_q;
      sh_b_d      = sh_b_q;
      sh_w_d      = sh_w_q;
      red_d       = red_q;
      green_d     = green_q;
      blue_d      = blue_q;
      white_d     = white_q;
      frame_err_d = 1'b0;
      if (cs && (state_q != IDLE)) begin
         // Abort: only an error once at least one colour byte has landed.
         state_d     = IDLE;
         frame_err_d = (state_q != GET_R) && (state_q != COMMIT);
      end else begin
         case (state_q)
            IDLE:   if (accept && (byte_in == 8'hA5)) state_d = GET_R;
            GET_R:  if (accept) begin sh_r_d = byte_in; state_d = GET_G; end
            GET_G:  if (accept) begin sh_g_d = byte_in; state_d = GET_B; end
            GET_B:  if (accept) begin sh_b_d = byte_in; state_d = GET_W; end
            GET_W:  if (accept) begin
               sh_w_d = byte_in;
`ifdef RGBW_FRAME_CHECKSUM_EN
               state_d = GET_CHK;
`else
               state_d = COMMIT;
               red_d   = sh_r_d;
               green_d = sh_g_d;
               blue_d  = sh_b_d;
               white_d = sh_w_d;
`endif
            end
`ifdef RGBW_FRAME_CHECKSUM_EN
            GET_CHK: if (accept) begin
               if (byte_in == (sh_r_q ^ sh_g_q ^ sh_b_q ^ sh_w_q)) begin
                  state_d = COMMIT;
                  red_d   = sh_r_d;
                  green_d = sh_g_d;
                  blue_d  = sh_b_d;
                  white_d = sh_w_d;
               end else begin
                  state_d     = IDLE;
                  frame_err_d = 1'b1;
               end
            end
`endif
            // Outputs are loaded on the edge entering COMMIT so they appear with update.
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         rdy_q       <= 1'b0;
         sh_r_q      <= 8'h00;
         sh_g_q      <= 8'h00;
         sh_b_q      <= 8'h00;
         sh_w_q      <= 8'h00;
         red_q       <= 8'h00;
         green_q     <= 8'h00;
         blue_q      <= 8'h00;
         white_q     <= 8'h00;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         rdy_q       <= byte_rdy;
         sh_r_q      <= sh_r_d;
         sh_g_q      <= sh_g_d;
         sh_b_q      <= sh_b_d;
         sh_w_q      <= sh_w_d;
         red_q       <= red_d;
         green_q     <= green_d;
         blue_q      <= blue_d;
         white_q     <= white_d;
         frame_err_q <= frame_err_d;
      end
   end

   assign red       = red_q;
   assign green     = green_q;
   assign blue      = blue_q;
   assign white     = white_q;
   assign update    = (state_q == COMMIT);
   assign frame_err = frame_err_q;
   assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_rgbw_frame_decoder.sv
// Randomised self-checking bench for rgbw_frame_decoder against a byte-queue frame model.
module tb_rgbw_frame_decoder;
`ifdef RGBW_FRAME_CHECKSUM_EN
   localparam int FLEN = 6;
`else
   localparam int FLEN = 5;
`endif

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       cs = 1'b1;
   logic       byte_rdy = 1'b0;
   logic [7:0] byte_in = 8'h00;
   logic [7:0] red, green, blue, white;
   logic       update, frame_err, busy;

   int n_checks = 0;
   int n_fail = 0;
   int upd_cnt = 0;
   int err_cnt = 0;
   bit both_seen = 1'b0;

   // Reference model: accepted-byte queue plus expected results.
   logic [7:0] mq[$];
   logic [7:0] exp_r = 8'h00, exp_g = 8'h00, exp_b = 8'h00, exp_w = 8'h00;
   int exp_upd = 0;
   int exp_err = 0;

   rgbw_frame_decoder dut (
      .clk(clk), .reset(reset), .cs(cs), .byte_rdy(byte_rdy), .byte_in(byte_in),
      .red(red), .green(green), .blue(blue), .white(white),
      .update(update), .frame_err(frame_err), .busy(busy)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (update) upd_cnt++;
      if (frame_err) err_cnt++;
      if (update && frame_err) both_seen = 1'b1;
   end

   function automatic logic [7:0] chk_of(input logic [7:0] r, g, b, w);
      return r ^ g ^ b ^ w;
   endfunction

   task automatic model_byte(input logic [7:0] b);
      bit ok;
      if (mq.size() == 0 && b != 8'hA5) return;
      mq.push_back(b);
      if (mq.size() == FLEN) begin
         ok = 1'b1;
         if (FLEN == 6) ok = (mq[FLEN-1] == chk_of(mq[1], mq[2], mq[3], mq[4]));
         if (ok) begin
            exp_r = mq[1]; exp_g = mq[2]; exp_b = mq[3]; exp_w = mq[4];
            exp_upd++;
         end else begin
            exp_err++;
         end
         mq.delete();
      end
   endtask

   task automatic model_abort();
      if (mq.size() >= 2) exp_err++;
      mq.delete();
   endtask

   task automatic send_byte(input logic [7:0] b, input int width, input int gap);
      @(negedge clk);
      byte_in = b;
      byte_rdy = 1'b1;
      if (!cs) model_byte(b);
      repeat (width) @(negedge clk);
      byte_rdy = 1'b0;
      repeat (gap - 1) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] r, g, b, w, input int width, input bit good);
      logic [7:0] c;
      send_byte(8'hA5, width, 3);
      send_byte(r, width, 3);
      send_byte(g, width, 3);
      send_byte(b, width, 3);
      send_byte(w, width, 3);
      if (FLEN == 6) begin
         c = chk_of(r, g, b, w);
         if (!good) c = c ^ 8'h01;
         send_byte(c, width, 3);
      end
   endtask

   task automatic pulse_cs();
      @(negedge clk);
      cs = 1'b1;
      model_abort();
      repeat (2) @(negedge clk);
      cs = 1'b0;
   endtask

   task automatic settle_and_check(input string name);
      repeat (3) @(negedge clk);
      n_checks++;
      if ({red, green, blue, white} !== {exp_r, exp_g, exp_b, exp_w}) begin
         n_fail++;
         $display("FAIL %s outputs: got %h required %h", name, {red, green, blue, white}, {exp_r, exp_g, exp_b, exp_w});
      end
      n_checks++;
      if (upd_cnt !== exp_upd || err_cnt !== exp_err) begin
         n_fail++;
         $display("FAIL %s pulses: got upd=%0d err=%0d required upd=%0d err=%0d", name, upd_cnt, err_cnt, exp_upd, exp_err);
      end
      n_checks++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL %s busy: got %b required 0", name, busy);
      end
      $display("txn %s: rgbw=%h upd=%0d err=%0d", name, {red, green, blue, white}, upd_cnt, err_cnt);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      cs = 1'b0;
      mq.delete();
      @(negedge clk);
      n_checks++;
      if ({red, green, blue, white, update, frame_err, busy} !== 35'd0) begin
         n_fail++;
         $display("FAIL reset_state: got %h required 0", {red, green, blue, white, update, frame_err, busy});
      end
      $display("txn reset: rgbw=%h busy=%b", {red, green, blue, white}, busy);
   endtask

   task automatic test_basic();
      logic [7:0] last;
      send_byte(8'hA5, 1, 3);
      send_byte(8'h10, 1, 3);
      send_byte(8'h20, 1, 3);
      send_byte(8'h30, 1, 3);
      n_checks++;
      if (busy !== 1'b1 || {red, green, blue, white} !== 32'h0) begin
         n_fail++;
         $display("FAIL partial_frame: got busy=%b rgbw=%h required busy=1 rgbw=0", busy, {red, green, blue, white});
      end
      last = 8'h40;
      if (FLEN == 6) send_byte(8'h40, 1, 3);
      if (FLEN == 6) last = 8'h40;
      @(negedge clk);
      byte_in = last;
      byte_rdy = 1'b1;
      model_byte(last);
      @(negedge clk);
      n_checks++;
      if (update !== 1'b1 || {red, green, blue, white} !== 32'h10203040) begin
         n_fail++;
         $display("FAIL commit_latency: got update=%b rgbw=%h required update=1 rgbw=10203040", update, {red, green, blue, white});
      end
      byte_rdy = 1'b0;
      @(negedge clk);
      n_checks++;
      if (update !== 1'b0) begin
         n_fail++;
         $display("FAIL update_width: got %b required 0", update);
      end
      settle_and_check("basic");
   endtask

   task automatic test_wide_strobe();
      send_frame(8'h10, 8'h20, 8'h30, 8'h40, 2, 1'b1);
      settle_and_check("wide_strobe");
   endtask

   task automatic test_abort();
      send_byte(8'hA5, 1, 3);
      send_byte(8'h11, 2, 3);
      send_byte(8'h22, 1, 3);
      pulse_cs();
      settle_and_check("abort_after_g");
      send_byte(8'hA5, 1, 3);
      pulse_cs();
      settle_and_check("abort_in_get_r");
      // Byte coinciding with cs rising must be discarded.
      send_byte(8'hA5, 1, 3);
      send_byte(8'h55, 1, 3);
      @(negedge clk);
      cs = 1'b1;
      byte_in = 8'h66;
      byte_rdy = 1'b1;
      model_abort();
      @(negedge clk);
      byte_rdy = 1'b0;
      @(negedge clk);
      cs = 1'b0;
      settle_and_check("abort_same_cycle");
   endtask

   task automatic test_cs_idle();
      cs = 1'b1;
      send_byte(8'hA5, 1, 3);
      send_byte(8'h77, 1, 3);
      @(negedge clk);
      cs = 1'b0;
      send_byte(8'h12, 1, 3);
      send_byte(8'h34, 1, 3);
      send_byte(8'h56, 1, 3);
      send_byte(8'h78, 1, 3);
      settle_and_check("cs_high_ignored");
   endtask

   task automatic test_checksum();
      send_frame(8'h01, 8'h02, 8'h03, 8'h04, 1, 1'b0);
      settle_and_check("checksum_bad");
      send_frame(8'h01, 8'h02, 8'h03, 8'h04, 1, 1'b1);
      settle_and_check("checksum_good");
   endtask

   task automatic test_junk_and_reset();
      send_byte(8'h00, 1, 3);
      send_byte(8'hFF, 2, 3);
      send_frame(8'hC1, 8'hC2, 8'hC3, 8'hC4, 1, 1'b1);
      settle_and_check("leading_junk");
      send_byte(8'hA5, 1, 3);
      send_byte(8'h99, 1, 3);
      send_byte(8'h88, 1, 3);
      @(negedge clk);
      reset = 1'b1;
      cs = 1'b1;
      byte_in = 8'h77;
      byte_rdy = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      byte_rdy = 1'b0;
      cs = 1'b0;
      mq.delete();
      exp_r = 8'h00; exp_g = 8'h00; exp_b = 8'h00; exp_w = 8'h00;
      settle_and_check("reset_mid_frame");
   endtask

   task automatic test_random();
      int mode, njunk, k, width;
      logic [7:0] v[4];
      logic [7:0] j, c;
      for (int it = 0; it < 40; it++) begin
         njunk = $urandom_range(0, 2);
         for (int n = 0; n < njunk; n++) begin
            j = 8'($urandom_range(0, 255));
            if (j == 8'hA5) j = 8'h5A;
            send_byte(j, $urandom_range(1, 2), $urandom_range(2, 4));
         end
         for (int n = 0; n < 4; n++) v[n] = 8'($urandom_range(0, 255));
         mode = $urandom_range(0, 3);
         width = $urandom_range(1, 2);
         if (mode == 1) begin
            k = $urandom_range(1, FLEN - 1);
            send_byte(8'hA5, width, $urandom_range(2, 4));
            for (int n = 1; n < k; n++) begin
               if (n <= 4) c = v[n-1];
               else c = chk_of(v[0], v[1], v[2], v[3]);
               send_byte(c, width, $urandom_range(2, 4));
            end
            pulse_cs();
         end else begin
            send_frame(v[0], v[1], v[2], v[3], width, mode != 2);
         end
         settle_and_check($sformatf("random_%0d_mode%0d", it, mode));
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_wide_strobe();
      test_abort();
      test_cs_idle();
`ifdef RGBW_FRAME_CHECKSUM_EN
      test_checksum();
`endif
      test_junk_and_reset();
      test_random();
      n_checks++;
      if (both_seen !== 1'b0) begin
         n_fail++;
         $display("FAIL update_err_overlap: got %b required 0", both_seen);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
